// File: rtl/fsm_seq_pkg.sv
// Shared constants for the FSM sequence driver: one-hot state encoding,
// test-vector field positions, table geometry and error-counter helpers.
package fsm_seq_pkg;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int VEC_W  = 4;
    localparam int ERR_W  = 5;

    localparam logic [ERR_W-1:0] ERR_MAX = 5'd31;

    // Vector layout: {a6, x3, i3, exp_out}
    localparam int VEC_A6_BIT  = 3;
    localparam int VEC_X3_BIT  = 2;
    localparam int VEC_I3_BIT  = 1;
    localparam int VEC_EXP_BIT = 0;

    localparam int ST_IDLE_BIT  = 0;
    localparam int ST_RUN_BIT   = 1;
    localparam int ST_FLUSH_BIT = 2;
    localparam int ST_FIN_BIT   = 3;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'(1 << ST_IDLE_BIT),
        ST_RUN   = 4'(1 << ST_RUN_BIT),
        ST_FLUSH = 4'(1 << ST_FLUSH_BIT),
        ST_FIN   = 4'(1 << ST_FIN_BIT)
    } state_t;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (v == ERR_MAX) ? v : v + 5'd1;
    endfunction

endpackage

// File: rtl/fsm_seq_table.sv
// Test-vector storage: one write port, one asynchronous read port, every
// entry cleared by reset so a reset always leaves an all-zero table.
module fsm_seq_table #(
    parameter int DEPTH = fsm_seq_pkg::DEPTH
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            we_i,
    input  logic [fsm_seq_pkg::ADDR_W-1:0]  waddr_i,
    input  logic [fsm_seq_pkg::VEC_W-1:0]   wdata_i,
    input  logic [fsm_seq_pkg::ADDR_W-1:0]  raddr_i,
    output logic [fsm_seq_pkg::VEC_W-1:0]   rdata_o
);
    import fsm_seq_pkg::*;

    logic [VEC_W-1:0] rd_arr [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [VEC_W-1:0] entry_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    entry_q <= '0;
                end else if (we_i && (waddr_i == ADDR_W'(gi))) begin
                    entry_q <= wdata_i;
                end
            end

            assign rd_arr[gi] = entry_q;
        end
    endgenerate

    assign rdata_o = (int'(raddr_i) < DEPTH) ? rd_arr[raddr_i] : '0;

endmodule

// File: rtl/fsm_seq_driver.sv
// Replays stored {a6,x3,i3,exp_out} vectors into an FSM under test and counts
// output mismatches. Define FSM_SEQ_DRIVER_STOP_ON_ERR_EN to end a run on its first mismatch.
module fsm_seq_driver #(
    parameter int DEPTH = fsm_seq_pkg::DEPTH
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [fsm_seq_pkg::ADDR_W-1:0]  len,
    input  logic                            load_en,
    input  logic [fsm_seq_pkg::ADDR_W-1:0]  load_addr,
    input  logic [fsm_seq_pkg::VEC_W-1:0]   load_data,
    input  logic                            dut_out,
    output logic                            a6,
    output logic                            x3,
    output logic                            i3,
    output logic                            busy,
    output logic                            done,
    output logic [fsm_seq_pkg::ERR_W-1:0]   err_cnt,
    output logic                            pass
);
    import fsm_seq_pkg::*;

    state_t             state_q;
    logic [ADDR_W-1:0]  idx_q;
    logic [ADDR_W-1:0]  last_q;
    logic               exp_q;
    logic               chk_q;
    logic               a6_q;
    logic               x3_q;
    logic               i3_q;
    logic               busy_q;
    logic               done_q;
    logic [ERR_W-1:0]   err_q;

    logic               tbl_we;
    logic [VEC_W-1:0]   rd_vec;
    logic               mismatch;
    logic [ERR_W-1:0]   err_inc;

    // Writes land at the same edge a start is accepted, so the first read
    // one cycle later already sees the new entry.
    assign tbl_we = load_en && (state_q == ST_IDLE);

    fsm_seq_table #(
        .DEPTH (DEPTH)
    ) u_table (
        .clk     (clk),
        .rst     (rst),
        .we_i    (tbl_we),
        .waddr_i (load_addr),
        .wdata_i (load_data),
        .raddr_i (idx_q),
        .rdata_o (rd_vec)
    );

    assign mismatch = chk_q && (dut_out != exp_q);
    assign err_inc  = sat_inc(err_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            last_q  <= '0;
            exp_q   <= 1'b0;
            chk_q   <= 1'b0;
            a6_q    <= 1'b0;
            x3_q    <= 1'b0;
            i3_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    a6_q  <= 1'b0;
                    x3_q  <= 1'b0;
                    i3_q  <= 1'b0;
                    chk_q <= 1'b0;
                    if (start) begin
                        // len of 0 yields last index 15, i.e. a full 16-vector run
                        last_q  <= len - 4'd1;
                        idx_q   <= '0;
                        err_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a6_q  <= rd_vec[VEC_A6_BIT];
                    x3_q  <= rd_vec[VEC_X3_BIT];
                    i3_q  <= rd_vec[VEC_I3_BIT];
                    exp_q <= rd_vec[VEC_EXP_BIT];
                    chk_q <= 1'b1;
                    idx_q <= idx_q + 1'b1;
                    if (mismatch) begin
                        err_q <= err_inc;
                    end
                    if (idx_q == last_q) begin
                        state_q <= ST_FLUSH;
                    end
`ifdef FSM_SEQ_DRIVER_STOP_ON_ERR_EN
                    if (mismatch) begin
                        a6_q    <= 1'b0;
                        x3_q    <= 1'b0;
                        i3_q    <= 1'b0;
                        chk_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= ST_FIN;
                    end
`endif
                end
                ST_FLUSH: begin
                    a6_q  <= 1'b0;
                    x3_q  <= 1'b0;
                    i3_q  <= 1'b0;
                    chk_q <= 1'b0;
                    if (mismatch) begin
                        err_q <= err_inc;
                    end
                    busy_q  <= 1'b0;
                    state_q <= ST_FIN;
                end
                ST_FIN: begin
                    a6_q    <= 1'b0;
                    x3_q    <= 1'b0;
                    i3_q    <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign a6      = a6_q;
    assign x3      = x3_q;
    assign i3      = i3_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err_cnt = err_q;
    assign pass    = (err_q == '0);

endmodule

// File: doc/fsm_seq_driver.md
FSM_SEQ_DRIVER -- requirements
Module: fsm_seq_driver

Interface
REQ-001 Parameter DEPTH, default 16; number of stored test vectors.
REQ-002 clk  input  1  single clock; all flops update on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to run the stored sequence.
REQ-005 len  input  4  number of vectors to run; 0 means 16; sampled on accepted start.
REQ-006 load_en  input  1  table write strobe.
REQ-007 load_addr  input  4  table write address.
REQ-008 load_data  input  4  vector {a6, x3, i3, exp_out}, bit 3 down to bit 0.
REQ-009 dut_out  input  1  Moore output of the checked FSM.
REQ-010 a6, x3, i3  output  1 each  registered condition bits driven to the checked FSM.
REQ-011 busy  output  1  high from the cycle after an accepted start until done.
REQ-012 done  output  1  one-cycle pulse at end of run.
REQ-013 err_cnt  output  5  mismatch count for the last run; saturates at 31.
REQ-014 pass  output  1  high when err_cnt == 0; valid from done until the next accepted start.

Function
REQ-015 The FSM SHALL be one-hot with four states: IDLE, RUN, FLUSH, FIN.
REQ-016 In IDLE, start=1 SHALL be accepted, latch len, clear err_cnt and idx, and go to RUN.
REQ-017 In RUN, each cycle SHALL drive table[idx] onto a6/x3/i3 and increment idx; after the last vector, go to FLUSH.
REQ-018 The expected bit of vector k SHALL be compared with dut_out in the cycle after vector k is driven; a mismatch SHALL increment err_cnt.
REQ-019 FLUSH SHALL drive a6=x3=i3=0, perform the final compare, and go to FIN.
REQ-020 FIN SHALL assert done for exactly one cycle and return to IDLE.
REQ-021 Run latency SHALL be N+2 cycles from the start edge to done, where N is the effective len.
REQ-022 start while not in IDLE SHALL be ignored.
REQ-023 load_en SHALL write the table only in IDLE; writes while busy SHALL be dropped.
REQ-024 When load_en and start are asserted in the same cycle, the write SHALL complete first and the run SHALL use the new data.
REQ-025 err_cnt SHALL hold at 31 on further mismatches.
REQ-026 idx SHALL wrap from 15 to 0 without fault when len=0.
REQ-027 In IDLE and FIN, a6/x3/i3 SHALL be 0.

Reset
REQ-028 rst=1 SHALL immediately force IDLE and clear a6, x3, i3, busy, done, err_cnt, idx and all table entries; pass SHALL read 1.
REQ-029 rst asserted mid-run SHALL abort the run with no done pulse.

Configuration
REQ-030 With FSM_SEQ_DRIVER_STOP_ON_ERR_EN defined, the first mismatch SHALL move RUN or FLUSH directly to FIN (err_cnt=1, done pulses next cycle).
REQ-031 Without the macro, all N vectors SHALL always run.

Structure
REQ-032 A shared package/include fsm_seq_pkg SHALL hold the one-hot state localparams, the vector field bit positions and DEPTH.
REQ-033 Vector storage SHALL be a sub-module fsm_seq_table with 1 write port, 1 async read port and reset clear.

Verification
REQ-034 Load 4 vectors whose exp_out all match a loopback model, len=4, start -> done at cycle 6, err_cnt=0, pass=1.
REQ-035 Load vector 2 with wrong exp_out, len=4 -> err_cnt=1, pass=0; with STOP_ON_ERR_EN, done 1 cycle after the vector-2 compare.
REQ-036 len=0, dut_out stuck opposite to every exp_out -> 16 mismatches, busy for 17 cycles, err_cnt=16.
REQ-037 start pulsed again mid-run and load_en pulsed mid-run -> run unaffected, table entry unchanged.
REQ-038 rst pulse at RUN idx=2 -> all outputs 0 the same cycle, no done pulse, table read back as 0.
REQ-039 Run 40 mismatching vectors over three back-to-back runs with a forced-mismatch DUT -> err_cnt clears per run and never exceeds 31.
